// File: rtl/reglk_ctrl.sv
// Register-lock bank write controller.
// Round-robin arbitration of lock-set requests into a sticky lock bank.
// A JTAG unlock sweep clears the bank one word per cycle.
module reglk_ctrl #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned NUM_WORDS = 6,
  parameter int unsigned IDXW      = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*IDXW-1:0]   req_idx_i,
  input  logic [NUM_REQ*32-1:0]     req_mask_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      req_err_o,
  input  logic                      jtag_unlock_req_i,
  output logic                      jtag_unlock_ack_o,
  output logic                      busy_o,
  output logic [NUM_WORDS*32-1:0]   reglk_o
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NUM_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StWrite, StClear} state_e;

  state_e            r_state;
  state_e            w_state_d;
  logic [CntW-1:0]   r_cnt;
  logic [CntW-1:0]   w_cnt_d;
  logic [PtrW-1:0]   r_rr;
  logic [PtrW-1:0]   r_grant;
  logic [IDXW-1:0]   r_idx;
  logic [31:0]       r_mask;
  logic              r_unlock_q;
  logic              r_pend;
  logic [NUM_REQ-1:0] r_ready;
  logic              r_err;
  logic              r_ack;
  logic              r_busy;
  logic [31:0]       r_words [NUM_WORDS];

  logic              w_unlock_evt;
  logic              w_any;
  logic [PtrW-1:0]   w_gnt;
  logic [IDXW-1:0]   w_sel_idx;
  logic [31:0]       w_sel_mask;
  logic              w_last;

  assign w_unlock_evt = jtag_unlock_req_i & ~r_unlock_q;
  assign w_last       = (r_state == StClear) && (r_cnt == LastCnt);

  // Round-robin search: first valid requester at or above r_rr, with wrap
  always_comb begin
    int unsigned w_c;
    w_any      = 1'b0;
    w_gnt      = '0;
    w_sel_idx  = '0;
    w_sel_mask = '0;
    w_c        = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_c = 32'(r_rr) + i;
      if (w_c >= NUM_REQ) w_c = w_c - NUM_REQ;
      if (!w_any && req_valid_i[w_c]) begin
        w_any      = 1'b1;
        w_gnt      = PtrW'(w_c);
        w_sel_idx  = req_idx_i[w_c*IDXW +: IDXW];
        w_sel_mask = req_mask_i[w_c*32 +: 32];
      end
    end
  end

  // Next-state logic; unlock takes priority over requests in IDLE
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_unlock_evt || r_pend) begin
          w_state_d = StClear;
          w_cnt_d   = '0;
        end else if (w_any) begin
          w_state_d = StWrite;
        end
      end
      StWrite: w_state_d = StIdle;
      StClear: begin
        if (r_cnt == LastCnt) w_state_d = StIdle;
        else                  w_cnt_d   = r_cnt + CntW'(1);
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Control registers and registered status outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_rr       <= '0;
      r_grant    <= '0;
      r_idx      <= '0;
      r_mask     <= '0;
      r_unlock_q <= 1'b0;
      r_pend     <= 1'b0;
      r_ready    <= '0;
      r_err      <= 1'b0;
      r_ack      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_unlock_q <= jtag_unlock_req_i;
      r_busy     <= (w_state_d != StIdle);
      // Ack is raised for the final sweep cycle so it lines up with the last word
      r_ack      <= (w_state_d == StClear) && (w_cnt_d == LastCnt);
      r_ready    <= '0;
      r_err      <= 1'b0;
      if (r_state == StIdle && w_state_d == StWrite) begin
        r_grant <= w_gnt;
        r_idx   <= w_sel_idx;
        r_mask  <= w_sel_mask;
        for (int unsigned r = 0; r < NUM_REQ; r++) r_ready[r] <= (32'(w_gnt) == r);
        r_err   <= (32'(w_sel_idx) >= NUM_WORDS);
      end
      if (r_state == StWrite) begin
        if (32'(r_grant) == NUM_REQ - 1) r_rr <= '0;
        else                             r_rr <= r_grant + PtrW'(1);
      end
      // Completion of the sweep drops any unlock seen while busy
      if (w_last)                                  r_pend <= 1'b0;
      else if (w_unlock_evt && r_state != StIdle)  r_pend <= 1'b1;
    end
  end

  // Lock bank: OR-in on WRITE, zero one word per CLEAR cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned w = 0; w < NUM_WORDS; w++) r_words[w] <= '0;
    end else if (r_state == StWrite) begin
      for (int unsigned w = 0; w < NUM_WORDS; w++) begin
        if (32'(r_idx) == w) r_words[w] <= r_words[w] | r_mask;
      end
    end else if (r_state == StClear) begin
      for (int unsigned w = 0; w < NUM_WORDS; w++) begin
        if (32'(r_cnt) == w) r_words[w] <= '0;
      end
    end
  end

  for (genvar g = 0; g < NUM_WORDS; g++) begin : g_pack
    assign reglk_o[g*32 +: 32] = r_words[g];
  end

  assign req_ready_o       = r_ready;
  assign req_err_o         = r_err;
  assign jtag_unlock_ack_o = r_ack;
  assign busy_o            = r_busy;

endmodule

// File: tb/tb_reglk_ctrl.sv
// Directed self-checking bench for reglk_ctrl.
module tb_reglk_ctrl;

  localparam int NR = 4;
  localparam int NW = 6;
  localparam int IW = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR*IW-1:0]  req_idx;
  logic [NR*32-1:0]  req_mask;
  logic [NR-1:0]     req_ready;
  logic              req_err;
  logic              jtag;
  logic              ack;
  logic              busy;
  logic [NW*32-1:0]  reglk;

  logic [31:0] exp_w [NW];
  int errors = 0;
  int checks = 0;

  reglk_ctrl #(.NUM_REQ(NR), .NUM_WORDS(NW), .IDXW(IW)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .req_valid_i       (req_valid),
    .req_idx_i         (req_idx),
    .req_mask_i        (req_mask),
    .req_ready_o       (req_ready),
    .req_err_o         (req_err),
    .jtag_unlock_req_i (jtag),
    .jtag_unlock_ack_o (ack),
    .busy_o            (busy),
    .reglk_o           (reglk)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NW*32-1:0] packed_exp;
    logic [NW*32-1:0] v;
    for (int w = 0; w < NW; w++) v[w*32 +: 32] = exp_w[w];
    return v;
  endfunction

  task automatic set_req(input int r, input logic [2:0] idx, input logic [31:0] mask);
    req_idx[r*IW +: IW] = idx;
    req_mask[r*32 +: 32] = mask;
    req_valid[r] = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; jtag = 1'b0; req_valid = '0; req_idx = '0; req_mask = '0;
    step; step;
    for (int w = 0; w < NW; w++) exp_w[w] = '0;
    checks++; if (reglk !== '0) begin errors++; $display("FAIL reset_reglk: got %h want 0", reglk); end
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b want 0", req_ready); end
    checks++; if (req_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", req_err); end
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    step;
  endtask

  task automatic test_single_write;
    set_req(0, 3'd2, 32'h0000_00F0);
    step;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL w1_ready: got %b want 0001", req_ready); end
    checks++; if (req_err !== 1'b0) begin errors++; $display("FAIL w1_err: got %b want 0", req_err); end
    checks++; if (reglk !== packed_exp()) begin errors++; $display("FAIL w1_early: got %h want %h", reglk, packed_exp()); end
    req_valid[0] = 1'b0;
    step;
    exp_w[2] = 32'h0000_00F0;
    checks++; if (reglk !== packed_exp()) begin errors++; $display("FAIL w1_bank: got %h want %h", reglk, packed_exp()); end
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL w1_ready_pulse: got %b want 0", req_ready); end
  endtask

  task automatic test_sticky;
    set_req(1, 3'd2, 32'h0000_000F);
    step;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL st_ready: got %b want 0010", req_ready); end
    req_valid[1] = 1'b0;
    step;
    exp_w[2] = 32'h0000_00FF;
    checks++; if (reglk !== packed_exp()) begin errors++; $display("FAIL st_bank: got %h want %h", reglk, packed_exp()); end
    // Zero mask from requester 3: acked, no error, bank unchanged, pointer wraps to 0
    set_req(3, 3'd0, 32'h0);
    step;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL m0_ready: got %b want 1000", req_ready); end
    checks++; if (req_err !== 1'b0) begin errors++; $display("FAIL m0_err: got %b want 0", req_err); end
    req_valid[3] = 1'b0;
    step;
    checks++; if (reglk !== packed_exp()) begin errors++; $display("FAIL m0_bank: got %h want %h", reglk, packed_exp()); end
  endtask

  task automatic test_fairness;
    int order [6];
    int pos, t, last_t, lim;
    order = '{0, 1, 2, 3, 0, 2};
    for (int r = 0; r < NR; r++) set_req(r, 3'(r), 32'h100 << r);
    pos = 0;
    for (int round = 0; round < 2; round++) begin
      lim = (round == 0) ? 4 : 6;
      if (round == 1) begin
        set_req(0, 3'd4, 32'h1);
        set_req(2, 3'd5, 32'h2);
      end
      t = 0; last_t = -1;
      while (pos < lim && t < 20) begin
        step; t++;
        if (req_ready !== '0) begin
          checks++;
          if (req_ready !== (4'b0001 << order[pos])) begin
            errors++; $display("FAIL rr_grant%0d: got %b want %b", pos, req_ready, 4'b0001 << order[pos]);
          end
          checks++; if (req_err !== 1'b0) begin errors++; $display("FAIL rr_err%0d: got %b want 0", pos, req_err); end
          if (last_t >= 0) begin
            checks++;
            if (t - last_t != 2) begin errors++; $display("FAIL rr_spacing%0d: got %0d want 2", pos, t - last_t); end
          end
          last_t = t;
          req_valid = req_valid & ~req_ready;
          pos++;
        end
      end
      checks++; if (pos != lim) begin errors++; $display("FAIL rr_timeout%0d: got %0d grants want %0d", round, pos, lim); end
      req_valid = '0;
      step;
    end
    exp_w[0] = 32'h100; exp_w[1] = 32'h200; exp_w[2] = 32'h4FF; exp_w[3] = 32'h800;
    exp_w[4] = 32'h1;   exp_w[5] = 32'h2;
    checks++; if (reglk !== packed_exp()) begin errors++; $display("FAIL rr_bank: got %h want %h", reglk, packed_exp()); end
  endtask

  task automatic test_bad_index;
    set_req(3, 3'd7, 32'hFFFF_FFFF);
    step;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bad7_ready: got %b want 1000", req_ready); end
    checks++; if (req_err !== 1'b1) begin errors++; $display("FAIL bad7_err: got %b want 1", req_err); end
    req_valid[3] = 1'b0;
    step;
    checks++; if (req_err !== 1'b0) begin errors++; $display("FAIL bad7_err_pulse: got %b want 0", req_err); end
    checks++; if (reglk !== packed_exp()) begin errors++; $display("FAIL bad7_bank: got %h want %h", reglk, packed_exp()); end
    set_req(0, 3'd6, 32'hFFFF_FFFF);
    step;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bad6_ready: got %b want 0001", req_ready); end
    checks++; if (req_err !== 1'b1) begin errors++; $display("FAIL bad6_err: got %b want 1", req_err); end
    req_valid[0] = 1'b0;
    step;
    checks++; if (reglk !== packed_exp()) begin errors++; $display("FAIL bad6_bank: got %h want %h", reglk, packed_exp()); end
  endtask

  task automatic test_unlock;
    logic [NW*32-1:0] want;
    for (int w = 0; w < NW; w++) begin
      set_req(1, 3'(w), 32'hFFFF_FFFF);
      step;
      req_valid[1] = 1'b0;
      step;
      exp_w[w] = 32'hFFFF_FFFF;
    end
    checks++; if (reglk !== packed_exp()) begin errors++; $display("FAIL ul_fill: got %h want %h", reglk, packed_exp()); end
    set_req(0, 3'd1, 32'h0000_0011);
    jtag = 1'b1;
    for (int k = 0; k < NW; k++) begin
      step;
      for (int w = 0; w < NW; w++) exp_w[w] = (w < k) ? 32'h0 : 32'hFFFF_FFFF;
      want = packed_exp();
      checks++;
      if (busy !== 1'b1 || req_ready !== '0 || ack !== (k == NW - 1) || reglk !== want) begin
        errors++;
        $display("FAIL ul_sweep%0d: got busy=%b ready=%b ack=%b bank=%h want busy=1 ready=0 ack=%b bank=%h",
                 k, busy, req_ready, ack, reglk, (k == NW - 1), want);
      end
    end
    step;
    for (int w = 0; w < NW; w++) exp_w[w] = '0;
    checks++;
    if (busy !== 1'b0 || ack !== 1'b0 || reglk !== '0) begin
      errors++; $display("FAIL ul_done: got busy=%b ack=%b bank=%h want 0 0 0", busy, ack, reglk);
    end
    step;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL ul_req_after: got %b want 0001", req_ready); end
    req_valid[0] = 1'b0;
    step;
    exp_w[1] = 32'h0000_0011;
    checks++; if (reglk !== packed_exp()) begin errors++; $display("FAIL ul_req_bank: got %h want %h", reglk, packed_exp()); end
    for (int k = 0; k < 8; k++) begin
      step;
      checks++;
      if (busy !== 1'b0 || ack !== 1'b0) begin
        errors++; $display("FAIL ul_hold%0d: got busy=%b ack=%b want 0 0", k, busy, ack);
      end
    end
    jtag = 1'b0;
    step;
  endtask

  task automatic test_unlock_during_write;
    int n;
    set_req(1, 3'd3, 32'h5);
    step;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL uw_ready: got %b want 0010", req_ready); end
    jtag = 1'b1;
    req_valid[1] = 1'b0;
    step;
    exp_w[3] = 32'h5;
    checks++; if (reglk !== packed_exp()) begin errors++; $display("FAIL uw_bank: got %h want %h", reglk, packed_exp()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL uw_idle: got busy=%b want 0", busy); end
    step;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL uw_clear: got busy=%b want 1", busy); end
    n = 0;
    while (ack !== 1'b1 && n < 12) begin step; n++; end
    checks++; if (n != NW - 1) begin errors++; $display("FAIL uw_ack_time: got %0d want %0d", n, NW - 1); end
    step;
    for (int w = 0; w < NW; w++) exp_w[w] = '0;
    checks++;
    if (busy !== 1'b0 || reglk !== '0) begin
      errors++; $display("FAIL uw_done: got busy=%b bank=%h want 0 0", busy, reglk);
    end
    jtag = 1'b0;
    step;
  endtask

  task automatic test_reset_mid_clear;
    set_req(0, 3'd5, 32'h0000_ABCD);
    step; req_valid[0] = 1'b0; step;
    set_req(2, 3'd3, 32'h0000_1234);
    step; req_valid[2] = 1'b0; step;
    jtag = 1'b1;
    step; step; step; step;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rc_busy: got %b want 1", busy); end
    rst = 1'b1;
    jtag = 1'b0;
    step;
    checks++;
    if (reglk !== '0 || busy !== 1'b0 || ack !== 1'b0 || req_ready !== '0 || req_err !== 1'b0) begin
      errors++;
      $display("FAIL rc_outputs: got bank=%h busy=%b ack=%b ready=%b err=%b want all 0",
               reglk, busy, ack, req_ready, req_err);
    end
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step;
      checks++;
      if (ack !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL rc_quiet%0d: got ack=%b busy=%b want 0 0", k, ack, busy);
      end
    end
    // Pointer was 3 before reset; after reset it restarts at 0, so req1 wins over req3
    set_req(1, 3'd0, 32'h1);
    set_req(3, 3'd0, 32'h8);
    step;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rc_rrptr: got %b want 0010", req_ready); end
    req_valid = '0;
    step;
  endtask

  initial begin
    test_reset;
    test_single_write;
    test_sticky;
    test_fairness;
    test_bad_index;
    test_unlock;
    test_unlock_during_write;
    test_reset_mid_clear;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
